// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops bytes from an upstream FIFO whenever it is non-empty
// and packs them little-endian into BYTES_PER_WORD-byte words that are offered
// on a valid/ready port. Optional partial-word flush is built in when the
// PACKER_FLUSH_EN macro is defined; without it the block always emits full words.
module fifo_word_packer #(
  parameter int FIFO_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [FIFO_WIDTH-1:0]                fifo_data_out,
  input  logic                                 fifo_empty,
  output logic                                 fifo_read,
  output logic [FIFO_WIDTH*BYTES_PER_WORD-1:0] word_data,
  output logic                                 word_valid,
  input  logic                                 word_ready,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]  word_bytes
`ifdef PACKER_FLUSH_EN
  ,
  input  logic                                 flush
`endif
);

  localparam int CNT_W  = $clog2(BYTES_PER_WORD + 1);
  localparam int WORD_W = FIFO_WIDTH * BYTES_PER_WORD;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BYTES_PER_WORD);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   issued_q, issued_d;     // reads requested for this word
  logic [CNT_W-1:0]   captured_q, captured_d; // bytes landed in word_q
  logic               rd_pending_q, rd_pending_d;
  logic [WORD_W-1:0]  word_q, word_d;

  logic flush_req;
  logic flush_fire;

`ifdef PACKER_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // A flush only closes a word that holds bytes and has no byte in flight;
  // a flush arriving with a read pending waits one cycle for that byte.
  assign flush_fire = (state_q == FILL) && flush_req &&
                      (captured_q != '0) && !rd_pending_q;

  // Next-state, read request and byte capture.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d      = state_q;
    issued_d     = issued_q;
    captured_d   = captured_q;
    rd_pending_d = 1'b0;
    word_d       = word_q;
    fifo_read    = 1'b0;

    case (state_q)
      FILL: begin
        // Reads stop while a useful flush is being held, so the partial word
        // closes on exactly the bytes already requested.
        fifo_read = !rst && !fifo_empty && (issued_q < FULL_CNT) &&
                    !(flush_req && ((captured_q != '0) || rd_pending_q));
        rd_pending_d = fifo_read;
        if (fifo_read) begin
          issued_d = issued_q + CNT_W'(1);
        end

        if (rd_pending_q) begin
          for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (captured_q == CNT_W'(b)) begin
              word_d[b*FIFO_WIDTH +: FIFO_WIDTH] = fifo_data_out;
            end
          end
          captured_d = captured_q + CNT_W'(1);
          if (captured_d == FULL_CNT) begin
            state_d = DRAIN;
          end
        end else if (flush_fire) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (word_ready) begin
          state_d    = FILL;
          issued_d   = '0;
          captured_d = '0;
          word_d     = '0;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and datapath registers; reset discards any partially built word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the word register is reset too, because word_data must read 0 out of reset.
      state_q      <= FILL;
      issued_q     <= '0;
      captured_q   <= '0;
      rd_pending_q <= 1'b0;
      word_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q      <= state_d;
      issued_q     <= issued_d;
      captured_q   <= captured_d;
      rd_pending_q <= rd_pending_d;
      word_q       <= word_d;
    end
  end

  assign word_valid = (state_q == DRAIN);
  assign word_data  = word_q;

`ifdef PACKER_FLUSH_EN
  assign word_bytes = captured_q;
`else
  assign word_bytes = rst ? '0 : FULL_CNT;
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a behavioural FIFO feeds the packer, every byte
// accepted by the FIFO is queued as the expected stream, and a monitor rebuilds
// each expected word from that stream whenever a word is handed off.
module tb_fifo_word_packer;

  localparam int FW  = 8;
  localparam int BPW = 4;
  localparam int WW  = FW * BPW;
  localparam int CW  = $clog2(BPW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] fifo_data_out = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_read;
  logic [WW-1:0] word_data;
  logic          word_valid;
  logic          word_ready;
  logic [CW-1:0] word_bytes;
`ifdef PACKER_FLUSH_EN
  logic          flush;
`endif

  always #5 clk = ~clk;

  fifo_word_packer #(.FIFO_WIDTH(FW), .BYTES_PER_WORD(BPW)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_read     (fifo_read),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .word_bytes    (word_bytes)
`ifdef PACKER_FLUSH_EN
    ,
    .flush         (flush)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural 8-deep FIFO and expected byte stream ----------
  logic [FW-1:0] fq[$];
  logic [FW-1:0] exp_q[$];
  logic          wr_en = 1'b0;
  logic [FW-1:0] wr_data = '0;
  logic          fifo_clr = 1'b0;

  always @(posedge clk) begin
    if (fifo_clr) begin
      fq.delete();
      exp_q.delete();
    end else begin
      if (fifo_read && fq.size() != 0) fifo_data_out <= fq.pop_front();
      if (wr_en && fq.size() < 8) begin
        fq.push_back(wr_data);
        exp_q.push_back(wr_data);
      end
    end
    fifo_empty <= (fq.size() == 0);
  end

  // ---------------- monitor / scoreboard --------------------------------------
  int            words_seen = 0;
  logic [WW-1:0] last_word  = '0;
  logic [CW-1:0] last_bytes = '0;
  logic          hold_prev  = 1'b0;
  logic [WW-1:0] data_prev  = '0;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (fifo_read) check("read_while_empty", fifo_empty, 1'b0);
      if (hold_prev) begin
        check("hold_valid", word_valid, 1'b1);
        check("hold_data", word_data, data_prev);
      end
      if (word_valid && word_ready) begin
        logic [WW-1:0] exp_w;
        int nb;
        nb    = int'(word_bytes);
        exp_w = '0;
`ifdef PACKER_FLUSH_EN
        check("word_bytes_range", (nb >= 1 && nb <= BPW), 1'b1);
`else
        check("word_bytes", word_bytes, BPW);
`endif
        if (exp_q.size() < nb) begin
          check("stream_bytes_available", exp_q.size(), nb);
        end else begin
          for (int i = 0; i < nb && i < BPW; i++) exp_w[i*FW +: FW] = exp_q.pop_front();
          check("word_data", word_data, exp_w);
        end
        words_seen++;
        last_word  = word_data;
        last_bytes = word_bytes;
      end
      hold_prev = word_valid && !word_ready;
      data_prev = word_data;
    end
  end

  // ---------------- stimulus helpers (drive 1 time unit after posedge) --------
  task automatic wr(input logic [FW-1:0] b);
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_data = b;
  endtask

  task automatic wr_idle();
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int target, input int budget);
    int n = 0;
    while (words_seen < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("word_arrived_in_time", (words_seen >= target), 1'b1);
  endtask

  // Hard stop in case something wedges the bench outside a bounded wait.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random sequence ------------------------------
  initial begin
    int base;
    logic bad_data, bad_read, bad_valid;

    rst = 1'b1;
    word_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
    flush = 1'b0;
`endif
    #2;
    check("reset_valid", word_valid, 1'b0);
    check("reset_data", word_data, '0);
    check("reset_bytes", word_bytes, '0);
    check("reset_read", fifo_read, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset asserted with two bytes captured and a third in flight.
    wr(8'hC1); wr(8'hC2); wr(8'hC3); wr(8'hC4); wr_idle();
    #2 rst = 1'b1;
    #1;
    check("midword_reset_valid", word_valid, 1'b0);
    check("midword_reset_data", word_data, '0);
    check("midword_reset_bytes", word_bytes, '0);
    check("midword_reset_read", fifo_read, 1'b0);
    @(posedge clk); #1 fifo_clr = 1'b1;
    @(posedge clk); #1 fifo_clr = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    base = words_seen;
    word_ready = 1'b1;
    wr(8'hD1); wr(8'hD2); wr(8'hD3); wr(8'hD4); wr_idle();
    wait_words(base + 1, 50);
    check("fresh_word_after_reset", last_word, 32'hD4D3D2D1);

    // Single word: valid pulses once, five cycles after the first read.
    idle(3);
    base = words_seen;
    fork
      begin
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44); wr_idle();
      end
      begin
        int k = 0;
        logic [5:0] pat;
        @(negedge clk);
        while (!fifo_read && k < 50) begin
          @(negedge clk);
          k++;
        end
        check("first_read_seen", fifo_read, 1'b1);
        pat = '0;
        for (int n = 1; n <= 6; n++) begin
          @(negedge clk);
          pat[n-1] = word_valid;
          if (n == 5) begin
            check("single_word_data", word_data, 32'h44332211);
            check("single_word_bytes", word_bytes, BPW);
          end
        end
        check("valid_pulse_pattern", pat, 6'b010000);
      end
    join
    idle(3);

    // Backpressure: two words queued, the first held for 10 cycles.
    word_ready = 1'b0;
    base = words_seen;
    for (int i = 1; i <= 8; i++) wr(FW'(8'h11 * i));
    wr_idle();
    begin
      int k = 0;
      @(negedge clk);
      while (!word_valid && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    check("bp_valid_seen", word_valid, 1'b1);
    bad_data = 1'b0;
    bad_read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (word_data !== 32'h44332211) bad_data = 1'b1;
      if (fifo_read !== 1'b0) bad_read = 1'b1;
    end
    check("bp_data_held", bad_data, 1'b0);
    check("bp_no_read", bad_read, 1'b0);
    @(posedge clk); #1 word_ready = 1'b1;
    wait_words(base + 2, 60);
    check("bp_second_word", last_word, 32'h88776655);

    // Empty stall mid-word.
    idle(3);
    base = words_seen;
    wr(8'hA1); wr(8'hA2); wr_idle();
    bad_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (word_valid) bad_valid = 1'b1;
    end
    check("stall_no_early_word", bad_valid, 1'b0);
    @(posedge clk); #1;
    wr(8'hA3); wr(8'hA4); wr_idle();
    wait_words(base + 1, 50);
    check("stall_word", last_word, 32'hA4A3A2A1);

    // Partial word: flushed when enabled, otherwise waits for four bytes.
    idle(3);
    base = words_seen;
    wr(8'h5A); wr(8'h6B); wr_idle();
`ifdef PACKER_FLUSH_EN
    idle(4);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_words(base + 1, 50);
    check("flush_word", last_word, 32'h00006B5A);
    check("flush_bytes", last_bytes, 2);
`else
    bad_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (word_valid) bad_valid = 1'b1;
    end
    check("partial_word_waits", bad_valid, 1'b0);
    @(posedge clk); #1;
    wr(8'h7C); wr(8'h8D); wr_idle();
    wait_words(base + 1, 50);
    check("partial_completed_word", last_word, 32'h8D7C6B5A);
`endif

    // Random stress: random writes, random backpressure.
    idle(3);
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      wr_en      = (fq.size() < 7) && ($urandom_range(0, 1) == 1);
      wr_data    = FW'($urandom);
      word_ready = ($urandom_range(0, 3) != 0);
`ifdef PACKER_FLUSH_EN
      flush      = ($urandom_range(0, 15) == 0);
`endif
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    word_ready = 1'b1;
`ifdef PACKER_FLUSH_EN
    flush = 1'b0;
`endif
    @(posedge clk); #1;
    begin
      int pad;
      pad = (BPW - (exp_q.size() % BPW)) % BPW;
      for (int i = 0; i < pad; i++) wr(FW'($urandom));
      wr_idle();
    end
    begin
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin
        @(posedge clk);
        k++;
`ifdef PACKER_FLUSH_EN
        #1 flush = (k == 50);
`endif
      end
      #1;
    end
`ifdef PACKER_FLUSH_EN
    flush = 1'b0;
`endif
    check("stream_fully_drained", exp_q.size(), 0);
    check("words_seen_nonzero", (words_seen > 100), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Read-side consumer of the 8-deep × 8-bit FIFO: pops bytes whenever the FIFO is non-empty and packs them little-endian into BYTES_PER_WORD-byte words, presented on a valid/ready output port. It never reads an empty FIFO, so the FIFO's read-on-empty warning stays silent. It sits directly downstream of the FIFO and feeds the word-wide datapath.

## Interface
- FIFO_WIDTH, default 8: byte width; must match the FIFO data width.
- BYTES_PER_WORD, default 4: bytes per output word; legal range 2..8.
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after fifo_read is sampled.
- fifo_empty  input  1  FIFO empty flag.
- fifo_read  output  1  pop request to the FIFO; combinational from state and fifo_empty.
- word_data  output  FIFO_WIDTH*BYTES_PER_WORD  packed word; byte 0 in bits [FIFO_WIDTH-1:0].
- word_valid  output  1  word_data holds a complete word.
- word_ready  input  1  downstream accepts the word.
- word_bytes  output  $clog2(BYTES_PER_WORD+1)  number of valid bytes in word_data.
- flush  input  1  present only with PACKER_FLUSH_EN (see Configuration).

## Operation
- Two states: FILL and DRAIN. Reset state is FILL.
- FILL:
  - fifo_read = !fifo_empty && (issued < BYTES_PER_WORD).
  - issued increments on each edge where fifo_read = 1.
  - A registered rd_pending flag marks that a byte lands on the next edge. On that edge, fifo_data_out is written into byte slot `captured`, and captured increments.
  - When captured reaches BYTES_PER_WORD, the state moves to DRAIN on that same edge.
- DRAIN:
  - word_valid = 1; word_data and word_bytes are held stable; fifo_read = 0.
  - On an edge with word_valid && word_ready: state returns to FILL, issued and captured clear, and word_data clears to 0.
- Back-to-back reads are allowed: fifo_empty is reevaluated every cycle from the FIFO's updated count.
- word_valid is never withdrawn before acceptance.
- Reset values: fifo_read 0, word_valid 0, word_data 0, word_bytes 0, issued 0, captured 0, rd_pending 0.
- Async reset mid-word discards all captured bytes.
  - A read already sampled by the FIFO before reset is lost, because the FIFO pointer has advanced. This is accepted behaviour.

## Timing
- A FIFO read sampled at edge E delivers its byte into the packer at edge E+1.
- With the FIFO continuously non-empty and BYTES_PER_WORD = 4:
  - Reads are sampled at edges E..E+3 and captured at E+1..E+4.
  - word_valid rises after E+4.
  - If word_ready = 1, the word transfers at E+5.
  - The next fifo_read is high after E+5 and is sampled at E+6.
- Sustained throughput: one word per BYTES_PER_WORD+2 cycles.
- If fifo_empty rises mid-word, reads pause and the word waits; captured bytes are retained indefinitely.
- word_ready may be held high before word_valid; no combinational path exists from word_ready to word_valid.

## Configuration
- Macro: PACKER_FLUSH_EN.
- Defined:
  - The flush input exists.
  - flush = 1 in FILL with captured > 0 and rd_pending = 0 forces DRAIN on that edge.
  - The partial word is emitted with unused upper bytes = 0 and word_bytes = captured.
  - flush suppresses fifo_read in the cycle it is high.
  - flush with captured = 0, or in DRAIN, is ignored.
  - flush while rd_pending = 1 waits for the pending byte, then flushes, provided flush is still high.
- Undefined:
  - No flush port.
  - word_bytes is constant BYTES_PER_WORD (0 during reset).

## Test plan
- Reset: assert rst mid-FILL with captured = 2. Outputs go to 0 immediately, asynchronously. After release, the first word is built from fresh bytes only.
- Single word: preload the FIFO with 0x11, 0x22, 0x33, 0x44 and hold word_ready = 1.
  - Expect word_data = 0x44332211 and word_bytes = 4.
  - word_valid is high for exactly one cycle, 5 cycles after the first fifo_read.
- Backpressure: fill 8 bytes and hold word_ready = 0 for 10 cycles.
  - word_data stays 0x44332211 and fifo_read stays 0 throughout.
  - After release, the second word is 0x88776655.
- Empty stall: write 0xA1, 0xA2, wait 20 cycles, then write 0xA3, 0xA4.
  - fifo_read is never high while fifo_empty = 1.
  - The word is 0xA4A3A2A1.
- Flush (PACKER_FLUSH_EN): write 0x5A, 0x6B, then pulse flush after both bytes are captured.
  - Expect word_data = 0x00006B5A and word_bytes = 2.
  - Repeat the run without the macro: the word completes only after 4 bytes.
- Random stress: random writes and random word_ready over 10k cycles.
  - Output byte stream equals input byte stream.
  - No read-on-empty.
  - word_data is stable while word_valid && !word_ready.
